// File: rtl/shift_pkg.sv
// Shared encodings and the operand bundle handed from the issue stage to the shifter.
package shift_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      SH_SLL = 2'b00,
      SH_SRL = 2'b01,
      SH_SRA = 2'b10
   } shift_type_e;

   localparam logic [6:0] OP_IMM  = 7'b0010011;
   localparam logic [6:0] OP_REG  = 7'b0110011;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SRA  = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [4:0]      shamt;
      shift_type_e     sh_type;
      logic [4:0]      rd;
      logic            illegal;
   } shift_op_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational recogniser for RV32I shifts; builds the shifter operand bundle.
module shift_decode
   import shift_pkg::*;
(
   input  logic [31:0] instr,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        is_shift,
   output shift_op_t   op
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;
   logic       unused_bits;

   assign opcode      = instr[6:0];
   assign funct3      = instr[14:12];
   assign funct7      = instr[31:25];
   assign unused_bits = ^{instr[19:15], rs2[31:5]};

   always_comb begin
      is_shift = 1'b0;
      legal    = 1'b0;
      op       = '0;
      if ((opcode == OP_IMM || opcode == OP_REG) &&
          (funct3 == F3_SLL || funct3 == F3_SR)) begin
         is_shift = 1'b1;
         op.rd    = instr[11:7];
         legal    = (funct7 == F7_ZERO) || (funct3 == F3_SR && funct7 == F7_SRA);
         // Malformed encodings still occupy a slot so EX can raise the trap in order.
         if (legal) begin
            op.a     = rs1;
            op.shamt = (opcode == OP_IMM) ? instr[24:20] : rs2[4:0];
            if (funct3 == F3_SLL)
               op.sh_type = SH_SLL;
            else if (funct7 == F7_SRA)
               op.sh_type = SH_SRA;
            else
               op.sh_type = SH_SRL;
         end else begin
            op.illegal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shift_issue_stage.sv
// Two-entry skid-buffered issue stage feeding the combinational shifter.
// Handshake: a side transfers on a cycle where valid & ready are both high at the edge.
module shift_issue_stage
   import shift_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [4:0]      out_shamt,
   output logic [1:0]      out_type,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   // Bit 0 = main valid, bit 1 = skid valid, so both handshake outputs come straight off flops.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } buf_state_e;

   buf_state_e state, state_nxt;
   shift_op_t  main_q, skid_q, dec_op;
   logic       dec_is_shift;
   logic       in_fire, out_fire;
   logic       load_main, load_skid, move_skid;

   shift_decode u_decode (
      .instr    (in_instr),
      .rs1      (in_rs1),
      .rs2      (in_rs2),
      .is_shift (dec_is_shift),
      .op       (dec_op)
   );

   assign in_ready  = ~state[1];
   assign out_valid = state[0];
   assign in_fire   = in_valid & in_ready & ~flush & dec_is_shift;
   assign out_fire  = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: if (in_fire) begin
               state_nxt = ONE;
               load_main = 1'b1;
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_nxt = TWO;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: if (out_fire) begin
               state_nxt = ONE;
               move_skid = 1'b1;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else begin
         state <= state_nxt;
         if (load_main)
            main_q <= dec_op;
         else if (move_skid)
            main_q <= skid_q;
         if (load_skid)
            skid_q <= dec_op;
      end
   end

   assign out_a       = main_q.a;
   assign out_shamt   = main_q.shamt;
   assign out_type    = main_q.sh_type;
   assign out_rd      = main_q.rd;
   assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage with hand-computed expected values.
module tb_shift_issue_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [4:0]  out_shamt;
   logic [1:0]  out_type;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] I_SLLI = 32'h0030_9293;  // slli x5,x1,3
   localparam logic [31:0] I_SRAI = 32'h41F1_5313;  // srai x6,x2,31
   localparam logic [31:0] I_SRL  = 32'h0041_D3B3;  // srl  x7,x3,x4
   localparam logic [31:0] I_BAD  = 32'h0230_9293;  // slli with instr[25]=1
   localparam logic [31:0] I_ADDI = 32'h0010_8093;  // addi x1,x1,1

   shift_issue_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_instr    (in_instr),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_a       (out_a),
      .out_shamt   (out_shamt),
      .out_type    (out_type),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic v, input logic [31:0] a,
                            input logic [4:0] sh, input logic [1:0] ty,
                            input logic [4:0] rd, input logic ill);
      check({tag, ".valid"},   {31'd0, out_valid},   {31'd0, v});
      check({tag, ".a"},       out_a,                a);
      check({tag, ".shamt"},   {27'd0, out_shamt},   {27'd0, sh});
      check({tag, ".type"},    {30'd0, out_type},    {30'd0, ty});
      check({tag, ".rd"},      {27'd0, out_rd},      {27'd0, rd});
      check({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, ill});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                        input logic [31:0] r2);
      in_valid = v;
      in_instr = ins;
      in_rs1   = r1;
      in_rs2   = r2;
   endtask

   initial begin
      rst_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      #2 rst_n = 1'b0;
      // Inputs presented during reset must be ignored.
      drive(1'b1, I_SLLI, 32'hDEAD_BEEF, 32'h0);
      step(); step();
      check_out("reset", 1'b0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0);
      check("reset.in_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      #2 rst_n = 1'b1;
      step();
      check("idle.valid", {31'd0, out_valid}, 32'd0);

      // Single SLLI, one-cycle latency.
      out_ready = 1'b1;
      drive(1'b1, I_SLLI, 32'h0000_00F0, 32'h0);
      step();
      check_out("slli", 1'b1, 32'h0000_00F0, 5'd3, 2'b00, 5'd5, 1'b0);

      // SRAI while SLLI drains: main reloaded in ONE.
      drive(1'b1, I_SRAI, 32'h8000_0000, 32'h0);
      step();
      check_out("srai", 1'b1, 32'h8000_0000, 5'd31, 2'b10, 5'd6, 1'b0);

      drive(1'b1, I_SRL, 32'h1234_5678, 32'hFFFF_FFE4);
      step();
      check_out("srl", 1'b1, 32'h1234_5678, 5'd4, 2'b01, 5'd7, 1'b0);

      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("drain.valid", {31'd0, out_valid}, 32'd0);

      // Back-pressure: A, B buffered; C held by ID.
      out_ready = 1'b0;
      drive(1'b1, I_SLLI, 32'h0000_0001, 32'h0);
      step();
      check("bp1.in_ready", {31'd0, in_ready}, 32'd1);
      check_out("bp1", 1'b1, 32'h1, 5'd3, 2'b00, 5'd5, 1'b0);
      drive(1'b1, I_SRAI, 32'h0000_0002, 32'h0);
      step();
      check("bp2.in_ready", {31'd0, in_ready}, 32'd0);
      check_out("bp2", 1'b1, 32'h1, 5'd3, 2'b00, 5'd5, 1'b0);
      drive(1'b1, I_SRL, 32'h0000_0003, 32'hFFFF_FFE4);
      step();
      check("bp3.in_ready", {31'd0, in_ready}, 32'd0);
      check_out("bp3.hold", 1'b1, 32'h1, 5'd3, 2'b00, 5'd5, 1'b0);
      out_ready = 1'b1;
      step();
      check_out("bp.drain_b", 1'b1, 32'h2, 5'd31, 2'b10, 5'd6, 1'b0);
      check("bp.drain_b.in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check_out("bp.drain_c", 1'b1, 32'h3, 5'd4, 2'b01, 5'd7, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("bp.empty", {31'd0, out_valid}, 32'd0);

      // Malformed shift emitted as illegal; ADDI discarded.
      out_ready = 1'b0;
      drive(1'b1, I_BAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      check_out("illegal", 1'b1, 32'h0, 5'd0, 2'b00, 5'd5, 1'b1);
      out_ready = 1'b1;
      drive(1'b1, I_ADDI, 32'h5555_5555, 32'h0);
      step();
      check("addi.valid", {31'd0, out_valid}, 32'd0);
      step();
      check("addi.still_empty", {31'd0, out_valid}, 32'd0);
      check("addi.in_ready", {31'd0, in_ready}, 32'd1);

      // Flush in TWO with an input presented.
      out_ready = 1'b0;
      drive(1'b1, I_SLLI, 32'h0000_0011, 32'h0);
      step();
      drive(1'b1, I_SRAI, 32'h0000_0022, 32'h0);
      step();
      check("flush2.pre_in_ready", {31'd0, in_ready}, 32'd0);
      flush = 1'b1;
      drive(1'b1, I_SRL, 32'h0000_0033, 32'h4);
      step();
      check("flush2.valid", {31'd0, out_valid}, 32'd0);
      check("flush2.in_ready", {31'd0, in_ready}, 32'd1);
      // Flush in ONE: the simultaneously offered input must also be dropped.
      flush = 1'b0;
      drive(1'b1, I_SLLI, 32'h0000_0044, 32'h0);
      step();
      check("flush1.pre_valid", {31'd0, out_valid}, 32'd1);
      flush = 1'b1;
      drive(1'b1, I_SRAI, 32'h0000_0055, 32'h0);
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      out_ready = 1'b1;
      check("flush1.valid", {31'd0, out_valid}, 32'd0);
      step();
      check("flush1.never_emitted", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset mid-cycle while in TWO.
      out_ready = 1'b0;
      drive(1'b1, I_SRAI, 32'h0000_0066, 32'h0);
      step();
      drive(1'b1, I_SRL, 32'h0000_0077, 32'h8);
      step();
      check("areset.pre_in_ready", {31'd0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check_out("areset", 1'b0, 32'h0, 5'd0, 2'b00, 5'd0, 1'b0);
      check("areset.in_ready", {31'd0, in_ready}, 32'd1);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      check("areset.after_valid", {31'd0, out_valid}, 32'd0);
      drive(1'b1, I_SLLI, 32'h0000_0088, 32'h0);
      step();
      check_out("areset.resume", 1'b1, 32'h88, 5'd3, 2'b00, 5'd5, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      step();
      check("final.empty", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage directly upstream of the combinational `Shifter` in the execute path. It accepts decoded-register-read instructions from ID, recognises RV32I shift instructions (SLL/SRL/SRA, SLLI/SRLI/SRAI), and selects the shift amount from the immediate or from rs2. It presents `{a, shamt, type, rd}` to the shifter through a two-entry skid buffer with valid/ready handshakes on both sides, plus flush support.

## Interface
- `XLEN`, default 32: operand width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  kill all buffered entries; the input presented in the same cycle is also dropped.
- `in_valid`  in  1  ID presents an instruction.
- `in_ready`  out  1  stage can accept; equals NOT skid-entry-valid, driven straight from a register.
- `in_instr`  in  32  raw instruction word.
- `in_rs1`  in  32  rs1 value, already forwarded.
- `in_rs2`  in  32  rs2 value, already forwarded.
- `out_valid`  out  1  shifter operands valid.
- `out_ready`  in  1  downstream (EX/MEM) accepts.
- `out_a`  out  32  value to shift (rs1).
- `out_shamt`  out  5  shift amount.
- `out_type`  out  2  shift type: 00 SLL, 01 SRL, 10 SRA. Never 11.
- `out_rd`  out  5  destination register.
- `out_illegal`  out  1  malformed shift encoding.

## Operation
- Input transfer occurs when `in_valid & in_ready & ~flush`. Output transfer occurs when `out_valid & out_ready`.
- Decode:
  - Opcode 0010011 (OP-IMM):
    - funct3 001 with instr[31:25]=0000000 → SLLI.
    - funct3 101 with instr[31:25]=0000000 → SRLI.
    - funct3 101 with instr[31:25]=0100000 → SRAI.
    - shamt = instr[24:20].
  - Opcode 0110011 (OP): same funct3/funct7 rules → SLL/SRL/SRA, with shamt = in_rs2[4:0].
  - Other shift-opcode/funct3 combinations with a bad funct7 (including instr[25]=1 on OP-IMM): entry is emitted with `out_illegal`=1, type 00, shamt 0, a 0.
  - All other instructions are accepted and silently discarded: no entry, no output.
- Buffer states:
  - EMPTY (no entries).
  - ONE (main entry valid).
  - TWO (main and skid valid, `in_ready`=0).
- Transitions:
  - EMPTY + shift in → ONE.
  - ONE + in + out → ONE, main reloaded.
  - ONE + in, no out → TWO, the new entry goes to skid.
  - ONE + out, no in → EMPTY.
  - TWO + out → ONE, skid moves to main.
  - Any state + flush → EMPTY.
  - A discarded (non-shift) input counts as no-in.
- `out_*` always reflect the main entry; order is strictly FIFO.

## Timing
- Reset (async, while `rst_n`=0): state EMPTY, `out_valid`=0, `in_ready`=1, `out_a`=0, `out_shamt`=0, `out_type`=00, `out_rd`=0, `out_illegal`=0. Inputs are ignored until the first edge after deassertion.
- Latency: an instruction accepted at edge N appears with `out_valid`=1 after edge N when the buffer was EMPTY or being drained.
- Throughput: 1 per cycle with `out_ready` held high. When `out_ready`=0, at most 2 entries are held, then `in_ready` drops in the next cycle.
- `out_*` hold stable while `out_valid & ~out_ready`.
- Flush has priority over simultaneous in/out transfers; state is EMPTY after the edge.
- Reset asserted mid-operation clears both entries immediately (asynchronously). No partial output.

## Structure
- Package `shift_pkg`:
  - type encodings `SH_SLL`/`SH_SRL`/`SH_SRA`.
  - opcodes `OP_IMM`/`OP_REG`.
  - funct3 `F3_SLL`/`F3_SR`.
  - funct7 `F7_ZERO`/`F7_SRA`.
  - a packed struct `shift_op_t {a, shamt, type, rd, illegal}`.
- One combinational sub-module, `shift_decode`: instr, rs1, rs2 → `{is_shift, shift_op_t}`. The top level holds only the two `shift_op_t` registers, the valid bits and the handshake logic.

## Test plan
- SLLI x5,x1,3 (0x00309293), rs1=0x0000_00F0, out_ready=1 → next cycle: out_a=0xF0, shamt=3, type=00, rd=5, illegal=0.
- SRAI x6,x2,31 (0x41F15313), rs1=0x8000_0000 → shamt=31, type=10, rd=6. SRL x7,x3,x4 (0x0041D3B3) with rs2=0xFFFF_FFE4 → shamt=4, type=01, rd=7.
- Back-pressure: three shift instructions issued back-to-back with out_ready=0:
  - in_ready drops after the second acceptance.
  - the third is held by ID.
  - out_ready=1 afterwards drains all three in order over 3 cycles.
- Malformed SLLI 0x02309293 → out_valid=1, illegal=1, type=00, shamt=0. ADDI 0x00108093 → accepted, no output.
- Flush in TWO state, with an instruction valid in the same cycle → out_valid=0 next cycle, in_ready=1, the flushed input is never emitted.
- rst_n pulsed low mid-cycle while in TWO state → out_valid falls immediately, all outputs 0; normal operation resumes on the first edge after release.
